// File: rtl/ysyx_25010008_axi_pkg.sv
// Shared types and constants for the IFU/LSU AXI arbiter.
// Holds the read-FSM encoding, the master index and the fixed AXI field values.
package ysyx_25010008_axi_pkg;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_A_IFU = 3'd1,
    RD_A_LSU = 3'd2,
    RD_D_IFU = 3'd3,
    RD_D_LSU = 3'd4
  } rd_state_t;

  typedef enum logic {
    M_IFU = 1'b0,
    M_LSU = 1'b1
  } master_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ID     = 4'h0;

  function automatic master_t other_master(input master_t m);
    return (m == M_IFU) ? M_LSU : M_IFU;
  endfunction

endpackage

// File: rtl/ysyx_25010008_rr_arb2.sv
// Two-request round-robin arbiter. On a tie the master that did not win last
// time is chosen; the history only advances when a granted transaction finishes.
module ysyx_25010008_rr_arb2
  import ysyx_25010008_axi_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_ifu_i,
  input  logic req_lsu_i,
  input  logic done_i,
  input  logic done_idx_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  master_t last_grant_q;
  master_t last_grant_d;

  always_comb begin
    gnt_valid_o = req_ifu_i | req_lsu_i;
    if (req_ifu_i && req_lsu_i) begin
      gnt_idx_o = other_master(last_grant_q);
    end else if (req_lsu_i) begin
      gnt_idx_o = M_LSU;
    end else begin
      gnt_idx_o = M_IFU;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (done_i) begin
      last_grant_d = master_t'(done_idx_i);
    end
  end

  // Reset history to LSU so the very first tie is won by the IFU.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= M_LSU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ysyx_25010008_axi_arbiter.sv
// Serialises IFU and LSU reads onto one AXI4 AR/R port and passes LSU writes
// straight through. R beats are steered to the requesting master with no buffering.
module ysyx_25010008_axi_arbiter
  import ysyx_25010008_axi_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter logic [2:0] IFU_SIZE = 3'b010
) (
  input  logic              clock,
  input  logic              reset,
  // IFU read
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic [7:0]        ifu_arlen,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rlast,
  // LSU read
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  // LSU write
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic [2:0]        lsu_awsize,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wstrb,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  output logic [1:0]        lsu_bresp,
  // Master AR/R
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [3:0]        m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [3:0]        m_rid,
  // Master AW/W/B
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [3:0]        m_awid,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  input  logic [3:0]        m_bid,
  // Debug view of the read FSM
  output logic [2:0]        dbg_rd_state
);

  rd_state_t state_q;

  logic gnt_valid;
  logic gnt_idx;
  logic a_ifu, a_lsu, d_ifu, d_lsu;
  logic ar_hs;
  logic r_done;
  logic arb_done;

  // IDs are fixed at zero on issue, so returned IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{m_rid, m_bid};

  assign a_ifu  = (state_q == RD_A_IFU);
  assign a_lsu  = (state_q == RD_A_LSU);
  assign d_ifu  = (state_q == RD_D_IFU);
  assign d_lsu  = (state_q == RD_D_LSU);
  assign ar_hs  = m_arvalid & m_arready;
  assign r_done = m_rvalid & m_rready & m_rlast;

  assign arb_done = r_done & (d_ifu | d_lsu);

  ysyx_25010008_rr_arb2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .req_ifu_i   (ifu_arvalid),
    .req_lsu_i   (lsu_arvalid),
    .done_i      (arb_done),
    .done_idx_i  (d_lsu),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Requests are only sampled in IDLE, so one burst always finishes before
  // the next grant, and back-to-back bursts see two idle AR cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RD_IDLE;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (gnt_valid) begin
            state_q <= (gnt_idx == M_LSU) ? RD_A_LSU : RD_A_IFU;
          end
        end
        RD_A_IFU: if (ar_hs)  state_q <= RD_D_IFU;
        RD_A_LSU: if (ar_hs)  state_q <= RD_D_LSU;
        RD_D_IFU: if (r_done) state_q <= RD_IDLE;
        RD_D_LSU: if (r_done) state_q <= RD_IDLE;
        default:              state_q <= RD_IDLE;
      endcase
    end
  end

  assign dbg_rd_state = state_q;

  // AR channel: fields from the granted master, held as long as it holds them.
  assign m_arvalid   = (a_ifu & ifu_arvalid) | (a_lsu & lsu_arvalid);
  assign m_araddr    = a_lsu ? lsu_araddr : ifu_araddr;
  assign m_arlen     = a_lsu ? 8'd0 : ifu_arlen;
  assign m_arsize    = a_lsu ? lsu_arsize : IFU_SIZE;
  assign m_arburst   = BURST_INCR;
  assign m_arid      = AXI_ID;
  assign ifu_arready = a_ifu & m_arready;
  assign lsu_arready = a_lsu & m_arready;

  // R channel: combinational steering, error responses pass through untouched.
  assign m_rready   = (d_ifu & ifu_rready) | (d_lsu & lsu_rready);
  assign ifu_rvalid = d_ifu & m_rvalid;
  assign ifu_rdata  = m_rdata;
  assign ifu_rresp  = d_ifu ? m_rresp : RESP_OKAY;
  assign ifu_rlast  = d_ifu & m_rlast;
  assign lsu_rvalid = d_lsu & m_rvalid;
  assign lsu_rdata  = m_rdata;
  assign lsu_rresp  = d_lsu ? m_rresp : RESP_OKAY;

  // Write path: single-beat LSU stores, independent of the read FSM.
  assign m_awvalid   = lsu_awvalid;
  assign m_awaddr    = lsu_awaddr;
  assign m_awid      = AXI_ID;
  assign m_awlen     = 8'd0;
  assign m_awsize    = lsu_awsize;
  assign m_awburst   = BURST_INCR;
  assign lsu_awready = m_awready;
  assign m_wvalid    = lsu_wvalid;
  assign m_wdata     = lsu_wdata;
  assign m_wstrb     = lsu_wstrb;
  assign m_wlast     = 1'b1;
  assign lsu_wready  = m_wready;
  assign lsu_bvalid  = m_bvalid;
  assign lsu_bresp   = m_bresp;
  assign m_bready    = lsu_bready;

endmodule

// File: tb/tb_ysyx_25010008_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: behavioural slave, scoreboard queues for
// AR fields and R beats, a write pass-through vector table and read corner sequences.
module tb_ysyx_25010008_axi_arbiter;
  import ysyx_25010008_axi_pkg::*;

  localparam logic [2:0] IFU_SZ = 3'b010;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, ifu_rlast;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic [7:0]  ifu_arlen;
  logic [1:0]  ifu_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_rresp;
  logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] lsu_awaddr, lsu_wdata;
  logic [2:0]  lsu_awsize;
  logic [3:0]  lsu_wstrb;
  logic [1:0]  lsu_bresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [31:0] m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic [3:0]  m_arid, m_rid;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb, m_bid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;
  logic [2:0]  dbg_rd_state;

  ysyx_25010008_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .IFU_SIZE(3'b010)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_arlen(ifu_arlen), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
    .lsu_awsize(lsu_awsize), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_bid(m_bid), .dbg_rd_state(dbg_rd_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [48:0] ar_exp_q[$];   // {addr, len, size, burst, id}
  logic [34:0] ifu_exp_q[$];  // {data, resp, last}
  logic [33:0] lsu_exp_q[$];  // {data, resp}
  logic [93:0] wr_exp_q[$];
  int ifu_last_cyc = 0;
  int lsu_ar_cyc   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic fail_msg(input string name, input logic [127:0] got);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, required nothing", name, got);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h8000_0537;
      32'h8000_0004: return 32'h0005_0067;
      32'h8000_0008: return 32'h0000_0013;
      32'h8000_000C: return 32'h0000_0013;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Page 0x8000_02xx answers SLVERR to exercise error forwarding.
  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return (a[31:8] == 24'h80_0002) ? 2'b10 : 2'b00;
  endfunction

  function automatic void exp_ifu(input logic [31:0] a, input logic [7:0] len);
    ar_exp_q.push_back({a, len, IFU_SZ, 2'b01, 4'h0});
    for (int i = 0; i <= int'(len); i++) begin
      ifu_exp_q.push_back({mem_word(a + 32'(4 * i)), resp_for(a + 32'(4 * i)), (i == int'(len))});
    end
  endfunction

  function automatic void exp_lsu(input logic [31:0] a, input logic [2:0] sz);
    ar_exp_q.push_back({a, 8'd0, sz, 2'b01, 4'h0});
    lsu_exp_q.push_back({mem_word(a), resp_for(a)});
  endfunction

  // ---------------- behavioural slave ----------------
  logic        s_busy;
  logic [31:0] s_addr;
  logic [7:0]  s_left;
  assign m_arready = !s_busy;
  assign m_rid     = 4'h5;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_busy <= 1'b0; s_addr <= '0; s_left <= '0;
      m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0; m_rlast <= 1'b0;
    end else if (m_arvalid && m_arready) begin
      s_busy   <= 1'b1;
      s_addr   <= m_araddr;
      s_left   <= m_arlen;
      m_rvalid <= 1'b1;
      m_rdata  <= mem_word(m_araddr);
      m_rresp  <= resp_for(m_araddr);
      m_rlast  <= (m_arlen == 8'd0);
    end else if (m_rvalid && m_rready) begin
      if (m_rlast) begin
        m_rvalid <= 1'b0; m_rlast <= 1'b0; s_busy <= 1'b0;
      end else begin
        s_addr  <= s_addr + 32'd4;
        m_rdata <= mem_word(s_addr + 32'd4);
        m_rresp <= resp_for(s_addr + 32'd4);
        m_rlast <= (s_left == 8'd1);
        s_left  <= s_left - 8'd1;
      end
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (m_arvalid && m_arready) begin
        if (ar_exp_q.size() == 0) fail_msg("ar_unexpected", 128'(m_araddr));
        else check("ar_fields", 128'({m_araddr, m_arlen, m_arsize, m_arburst, m_arid}),
                   128'(ar_exp_q.pop_front()));
        if (lsu_arready) lsu_ar_cyc = cyc + 1;
      end
      if (ifu_rvalid && ifu_rready) begin
        if (ifu_exp_q.size() == 0) fail_msg("ifu_beat_unexpected", 128'(ifu_rdata));
        else check("ifu_beat", 128'({ifu_rdata, ifu_rresp, ifu_rlast}), 128'(ifu_exp_q.pop_front()));
        if (ifu_rlast) ifu_last_cyc = cyc + 1;
      end
      if (lsu_rvalid && lsu_rready) begin
        if (lsu_exp_q.size() == 0) fail_msg("lsu_beat_unexpected", 128'(lsu_rdata));
        else check("lsu_beat", 128'({lsu_rdata, lsu_rresp}), 128'(lsu_exp_q.pop_front()));
      end
      if (m_rvalid) check("r_exclusive", 128'({ifu_rvalid, lsu_rvalid} == 2'b11), 128'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ifu_ar(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    ifu_araddr = a; ifu_arlen = len; ifu_arvalid = 1'b1;
    do begin @(negedge clock); n++; end while (!ifu_arready && n < 60);
    if (!ifu_arready) fail_msg("ifu_ar_timeout", 128'(a));
    @(posedge clock); #1;
    ifu_arvalid = 1'b0;
  endtask

  task automatic lsu_ar(input logic [31:0] a, input logic [2:0] sz);
    int n = 0;
    lsu_araddr = a; lsu_arsize = sz; lsu_arvalid = 1'b1;
    do begin @(negedge clock); n++; end while (!lsu_arready && n < 60);
    if (!lsu_arready) fail_msg("lsu_ar_timeout", 128'(a));
    @(posedge clock); #1;
    lsu_arvalid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((ifu_exp_q.size() != 0 || lsu_exp_q.size() != 0 || ar_exp_q.size() != 0) && n < 200) begin
      @(negedge clock); n++;
    end
    if (n >= 200) begin
      fail_msg(name, 128'(ifu_exp_q.size() + lsu_exp_q.size() + ar_exp_q.size()));
      ifu_exp_q.delete(); lsu_exp_q.delete(); ar_exp_q.delete();
    end
    @(posedge clock); #1;
    check({name, "_idle"}, 128'(dbg_rd_state), 128'(RD_IDLE));
  endtask

  // ---------------- write pass-through vectors ----------------
  typedef struct {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        s_awready;
    logic        s_wready;
    logic        s_bvalid;
    logic [1:0]  s_bresp;
    logic [93:0] exp;  // {awvalid,awaddr,awsize,awlen,awburst,awid,wvalid,wdata,wstrb,wlast,bready,lsu_awready,lsu_wready,lsu_bvalid,lsu_bresp}
  } wr_vec_t;

  wr_vec_t wv[4];

  initial begin
    int bad;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [7:0]  len;

    wv[0] = '{1'b1, 32'hA000_03F8, 3'd0, 1'b1, 32'h41, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00,
              {1'b1, 32'hA000_03F8, 3'd0, 8'd0, 2'b01, 4'd0, 1'b1, 32'h41, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00}};
    wv[1] = '{1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00,
              {1'b0, 32'h0, 3'd0, 8'd0, 2'b01, 4'd0, 1'b0, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00}};
    wv[2] = '{1'b1, 32'h8000_1234, 3'd2, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10,
              {1'b1, 32'h8000_1234, 3'd2, 8'd0, 2'b01, 4'd0, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10}};
    wv[3] = '{1'b0, 32'hFFFF_FFFC, 3'd1, 1'b1, 32'h0000_FFFF, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01,
              {1'b0, 32'hFFFF_FFFC, 3'd1, 8'd0, 2'b01, 4'd0, 1'b1, 32'h0000_FFFF, 4'b0011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01}};

    reset = 1'b0;
    ifu_arvalid = 0; ifu_araddr = 0; ifu_arlen = 0; ifu_rready = 1;
    lsu_arvalid = 0; lsu_araddr = 0; lsu_arsize = 0; lsu_rready = 1;
    lsu_awvalid = 0; lsu_awaddr = 0; lsu_awsize = 0; lsu_wvalid = 0; lsu_wdata = 0;
    lsu_wstrb = 0; lsu_bready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;

    // Reset values, and the write path still follows its inputs under reset.
    #3;
    check("reset_rd", 128'({dbg_rd_state, m_arvalid, m_rready, ifu_arready, lsu_arready,
                            ifu_rvalid, lsu_rvalid}), 128'(0));
    lsu_awvalid = 1; m_awready = 1; #1;
    check("reset_wr_follow", 128'({m_awvalid, lsu_awready}), 128'(2'b11));
    lsu_awvalid = 0; m_awready = 0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // Write pass-through table.
    for (int i = 0; i < 4; i++) begin
      lsu_awvalid = wv[i].awvalid; lsu_awaddr = wv[i].awaddr; lsu_awsize = wv[i].awsize;
      lsu_wvalid = wv[i].wvalid; lsu_wdata = wv[i].wdata; lsu_wstrb = wv[i].wstrb;
      lsu_bready = wv[i].bready; m_awready = wv[i].s_awready; m_wready = wv[i].s_wready;
      m_bvalid = wv[i].s_bvalid; m_bresp = wv[i].s_bresp;
      wr_exp_q.push_back(wv[i].exp);
      #1;
      if (m_awvalid && m_wvalid && m_awaddr == 32'hA000_03F8) $display("[TB] uart: %c", m_wdata[7:0]);
      check("wr_vec", 128'({m_awvalid, m_awaddr, m_awsize, m_awlen, m_awburst, m_awid, m_wvalid,
                           m_wdata, m_wstrb, m_wlast, m_bready, lsu_awready, lsu_wready,
                           lsu_bvalid, lsu_bresp}), 128'(wr_exp_q.pop_front()));
    end
    check("wr_no_read", 128'({dbg_rd_state, m_arvalid, ifu_rvalid, lsu_rvalid}), 128'(0));
    lsu_awvalid = 0; lsu_wvalid = 0; m_bvalid = 0;
    @(posedge clock); #1;

    // Tie right after reset: IFU first, LSU granted two edges after IFU rlast.
    exp_ifu(32'h8000_0008, 8'd1);
    exp_lsu(32'h8000_0100, 3'd2);
    fork
      ifu_ar(32'h8000_0008, 8'd1);
      lsu_ar(32'h8000_0100, 3'd2);
    join
    wait_drained("tie1");
    check("tie1_gap", 128'(lsu_ar_cyc - ifu_last_cyc), 128'(2));

    // Second tie after an LSU win goes back to the IFU.
    exp_ifu(32'h8000_0020, 8'd2);
    exp_lsu(32'h8000_0104, 3'd0);
    fork
      ifu_ar(32'h8000_0020, 8'd2);
      lsu_ar(32'h8000_0104, 3'd0);
    join
    wait_drained("tie2");

    // Boot burst with one-cycle arbitration latency.
    exp_ifu(32'h8000_0000, 8'd3);
    ifu_araddr = 32'h8000_0000; ifu_arlen = 8'd3; ifu_arvalid = 1'b1;
    @(negedge clock);
    check("arb_lat_pre", 128'(m_arvalid), 128'(0));
    @(negedge clock);
    check("arb_lat_post", 128'({m_arvalid, ifu_arready, lsu_arready}), 128'(3'b110));
    @(posedge clock); #1;
    ifu_arvalid = 1'b0;
    wait_drained("boot");

    // LSU request during an IFU burst waits with arready low.
    exp_ifu(32'h8000_0000, 8'd3);
    exp_lsu(32'h8000_0100, 3'd2);
    ifu_ar(32'h8000_0000, 8'd3);
    bad = 0;
    fork
      lsu_ar(32'h8000_0100, 3'd2);
      begin
        for (int k = 0; k < 40 && ifu_exp_q.size() != 0; k++) begin
          @(negedge clock);
          if (lsu_arready && ifu_exp_q.size() != 0) bad++;
        end
      end
    join
    check("lsu_blocked", 128'(bad), 128'(0));
    wait_drained("lsu_wait");

    // R backpressure: IFU holds rready low for three cycles after beat 1.
    exp_ifu(32'h8000_0040, 8'd3);
    ifu_ar(32'h8000_0040, 8'd3);
    @(posedge clock); #1;
    ifu_rready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp_m_rready", 128'({m_rready, ifu_rvalid}), 128'(2'b01));
    end
    @(posedge clock); #1;
    ifu_rready = 1'b1;
    wait_drained("bp");

    // Error responses pass through without cutting the burst short.
    exp_ifu(32'h8000_0200, 8'd2);
    ifu_ar(32'h8000_0200, 8'd2);
    wait_drained("err_ifu");
    exp_lsu(32'h8000_0210, 3'd2);
    lsu_ar(32'h8000_0210, 3'd2);
    wait_drained("err_lsu");

    // Random IFU bursts with random rready.
    for (int it = 0; it < 3; it++) begin
      a = 32'h8000_0300 + 32'(16 * $urandom_range(0, 7));
      len = 8'($urandom_range(0, 3));
      exp_ifu(a, len);
      ifu_ar(a, len);
      for (int k = 0; k < 60 && ifu_exp_q.size() != 0; k++) begin
        ifu_rready = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
      end
      ifu_rready = 1'b1;
      wait_drained("rand_ifu");
    end

    // Random LSU reads with random rready.
    for (int it = 0; it < 4; it++) begin
      a = 32'h8000_0400 + 32'(4 * $urandom_range(0, 63));
      sz = 3'($urandom_range(0, 2));
      exp_lsu(a, sz);
      lsu_ar(a, sz);
      for (int k = 0; k < 60 && lsu_exp_q.size() != 0; k++) begin
        lsu_rready = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
      end
      lsu_rready = 1'b1;
      wait_drained("rand_lsu");
    end

    // Async reset after beat 2 of a 4-beat burst.
    exp_ifu(32'h8000_0000, 8'd3);
    ifu_ar(32'h8000_0000, 8'd3);
    bad = 0;
    while (ifu_exp_q.size() > 2 && bad < 50) begin
      @(posedge clock); bad++;
    end
    check("mid_reset_beats", 128'(ifu_exp_q.size()), 128'(2));
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_out", 128'({dbg_rd_state, m_arvalid, m_rready, ifu_arready, lsu_arready,
                                 ifu_rvalid, lsu_rvalid, ifu_rlast}), 128'(0));
    ifu_exp_q.delete(); ar_exp_q.delete(); lsu_exp_q.delete();
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    exp_ifu(32'h8000_0000, 8'd3);
    ifu_ar(32'h8000_0000, 8'd3);
    wait_drained("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
